// File: rtl/btn_op_select.sv
// Basys3 button front end: synchronizes and debounces four push-buttons, then latches
// a one-hot ALU operation that toggles, switches by priority, or clears.

module btn_op_select_lane #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btnRaw,
    output logic stable,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncChain;
    logic [CNT_W-1:0]       count;
    logic                   prevStable;
    logic                   synced;

    assign synced = syncChain[SYNC_STAGES-1];
    assign press  = stable & ~prevStable;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            syncChain  <= '0;
            count      <= '0;
            stable     <= 1'b0;
            prevStable <= 1'b0;
        end else begin
            syncChain  <= {syncChain[SYNC_STAGES-2:0], btnRaw};
            prevStable <= stable;
            // Any sample matching the accepted level restarts the stability window.
            if (synced == stable) begin
                count <= '0;
            end else if (count == CNT_MAX) begin
                stable <= synced;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

module btn_op_select #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] btn_i,
    input  logic       clear_i,
    output logic [3:0] operation_o,
    output logic       op_changed_o,
    output logic [3:0] btn_stable_o
);
    localparam int NUM_BTN = 4;

    logic [NUM_BTN-1:0] btnStable;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] opState;
    logic [NUM_BTN-1:0] opNext;
    logic [NUM_BTN-1:0] cand;
    logic               opChanged;

    for (genvar g = 0; g < NUM_BTN; g++) begin : gLane
        btn_op_select_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) uLane (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .btnRaw(btn_i[g]),
            .stable(btnStable[g]),
            .press (press[g])
        );
    end

    // State register: the selected operation is the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opState   <= '0;
            opChanged <= 1'b0;
        end else begin
            opState   <= opNext;
            opChanged <= (opNext != opState);
        end
    end

    // Presses other than the current selection win; lowest bit index has priority.
    always_comb begin
        opNext = opState;
        cand   = press & ~opState;
        if (clear_i) begin
            opNext = '0;
        end else if (cand != '0) begin
            opNext = cand & (~cand + NUM_BTN'(1));
        end else if (press != '0) begin
            opNext = '0;
        end
    end

    always_comb begin
        operation_o  = opState;
        op_changed_o = opChanged;
        btn_stable_o = btnStable;
    end
endmodule

// File: tb/tb_btn_op_select.sv
// Directed test-plan scenarios plus a randomized phase, every edge checked against
// a behavioural model of the button stage and selection rules.

module tb_btn_op_select;
    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic [3:0] operation;
    logic [3:0] btnStable;
    logic       opChanged;

    int checks   = 0;
    int failures = 0;

    // Model: raw samples in flight, run length of disagreeing samples per button
    logic [3:0] mSync [SYNC];
    int         run   [4];
    logic [3:0] mStable, mPrev, mOp;
    logic       mChg;

    btn_op_select #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_i       (btn),
        .clear_i     (clear),
        .operation_o (operation),
        .op_changed_o(opChanged),
        .btn_stable_o(btnStable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] selectOp(input logic [3:0] op, input logic [3:0] prs,
                                            input logic clr);
        logic [3:0] one;
        one = 4'b0001;
        if (clr) return 4'b0000;
        if (prs == 4'b0000) return op;
        for (int b = 0; b < 4; b++)
            if (prs[b] && !op[b]) return one << b;
        return 4'b0000;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < SYNC; i++) mSync[i] = 4'b0000;
        for (int b = 0; b < 4; b++) run[b] = 0;
        mStable = 4'b0000;
        mPrev   = 4'b0000;
        mOp     = 4'b0000;
        mChg    = 1'b0;
    endtask

    task automatic tick();
        logic [3:0] nxt;
        logic [3:0] synced;
        @(posedge clk);
        nxt   = selectOp(mOp, mStable & ~mPrev, clear);
        mChg  = (nxt != mOp);
        mOp   = nxt;
        mPrev = mStable;
        synced = mSync[SYNC-1];
        for (int b = 0; b < 4; b++) begin
            if (synced[b] == mStable[b]) begin
                run[b] = 0;
            end else begin
                run[b]++;
                if (run[b] == DEB) begin
                    mStable[b] = synced[b];
                    run[b] = 0;
                end
            end
        end
        for (int i = SYNC - 1; i > 0; i--) mSync[i] = mSync[i-1];
        mSync[0] = btn;
        #1;
        check("model op", operation, mOp);
        check("model changed", {3'b000, opChanged}, {3'b000, mChg});
        check("model stable", btnStable, mStable);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Called just after an edge check: asserts reset between edges, then releases on negedge.
    task automatic asyncReset();
        #2 rst = 1'b1;
        modelReset();
        #1;
        check("rst op", operation, 4'b0000);
        check("rst changed", {3'b000, opChanged}, 4'b0000);
        check("rst stable", btnStable, 4'b0000);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        modelReset();
        #1 rst = 1'b1;
        @(posedge clk);
        #2;
        check("reset op", operation, 4'b0000);
        check("reset changed", {3'b000, opChanged}, 4'b0000);
        check("reset stable", btnStable, 4'b0000);
        @(negedge clk) rst = 1'b0;

        // Clean press of L held 20 cycles
        btn = 4'b0010;
        ticks(5);
        check("L stable early", btnStable, 4'b0000);
        tick();
        check("L stable at 6", btnStable, 4'b0010);
        check("L op before 7", operation, 4'b0000);
        tick();
        check("L op at 7", operation, 4'b0010);
        check("L pulse at 7", {3'b000, opChanged}, 4'b0001);
        tick();
        check("L pulse single", {3'b000, opChanged}, 4'b0000);
        ticks(12);
        btn = 4'b0000;
        ticks(8);
        check("L held after release", operation, 4'b0010);

        // Select R, then toggle it off
        btn = 4'b0100;
        ticks(7);
        check("R selected", operation, 4'b0100);
        btn = 4'b0000;
        ticks(8);
        btn = 4'b0100;
        ticks(7);
        check("R toggled off", operation, 4'b0000);
        check("R toggle pulse", {3'b000, opChanged}, 4'b0001);
        btn = 4'b0000;
        ticks(8);

        // Bounce on U: 3-cycle highs never get through
        for (int k = 0; k < 5; k++) begin
            btn = 4'b0001;
            ticks(3);
            btn = 4'b0000;
            ticks(3);
        end
        check("bounce stable", btnStable, 4'b0000);
        check("bounce op", operation, 4'b0000);
        btn = 4'b0001;
        ticks(6);
        check("bounce op at 6", operation, 4'b0000);
        tick();
        check("bounce op at 7", operation, 4'b0001);
        btn = 4'b0000;
        ticks(8);

        // Toggle U off, then priority from NONE and from SEL
        btn = 4'b0001;
        ticks(7);
        check("U toggled off", operation, 4'b0000);
        btn = 4'b0000;
        ticks(8);
        btn = 4'b1001;
        ticks(7);
        check("U+D priority", operation, 4'b0001);
        btn = 4'b0000;
        ticks(8);
        btn = 4'b0011;
        ticks(7);
        check("U+L from U", operation, 4'b0010);
        btn = 4'b0000;
        ticks(8);

        // Clear wins over a simultaneous L press landing
        btn = 4'b1000;
        ticks(7);
        check("D selected", operation, 4'b1000);
        btn = 4'b0000;
        ticks(8);
        btn = 4'b0010;
        ticks(6);
        clear = 1'b1;
        tick();
        check("clear op", operation, 4'b0000);
        check("clear pulse", {3'b000, opChanged}, 4'b0001);
        clear = 1'b0;
        btn = 4'b0000;
        ticks(8);
        clear = 1'b1;
        tick();
        check("clear idle op", operation, 4'b0000);
        check("clear idle no pulse", {3'b000, opChanged}, 4'b0000);
        clear = 1'b0;
        tick();

        // Async reset two cycles into a D debounce, D held through release
        btn = 4'b1000;
        ticks(2);
        asyncReset();
        ticks(6);
        check("D after reset at 6", operation, 4'b0000);
        tick();
        check("D after reset at 7", operation, 4'b1000);
        btn = 4'b0000;
        ticks(8);

        // Randomized phase
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(11) == 0) btn[b] = ~btn[b];
            clear = ($urandom_range(19) == 0);
            if (c == 300) asyncReset();
            tick();
        end
        clear = 1'b0;
        btn = 4'b0000;
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
